// File: rtl/vga_pkg.sv
// Shared VGA constants for the 1024x768 pixel path.
// Geometry, channel slot layout and the colour palette.
package vga_pkg;

    localparam int H_ACTIVE = 1024;
    localparam int V_ACTIVE = 768;
    localparam int NUM_CH   = 13;
    localparam int SLOT_W   = 64;

    localparam logic [11:0] RGB_BLACK = 12'h000;
    localparam logic [11:0] RGB_WHITE = 12'hFFF;
    localparam logic [11:0] RGB_GREEN = 12'h0F0;
    localparam logic [11:0] RGB_RED   = 12'hF00;
    localparam logic [11:0] RGB_GRID  = 12'h444;

    // Bar height in rows for a 12-bit reading (0..511).
    function automatic logic [8:0] bar_height(input logic [11:0] val);
        return val[11:3];
    endfunction

endpackage

// File: rtl/signal_delay.sv
// Fixed-depth register pipeline with synchronous clear.
// Carries the timing bus alongside the pixel pipeline.
module signal_delay #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 2
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe [DEPTH];

    // Shift the bus one stage per clock; reset empties every stage.
    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/draw_bars.sv
// Bar-graph renderer: 13 channel bars, double-buffered at vblank start.
// Optional grid rows enabled by defining DRAW_BARS_GRID_EN.
module draw_bars
    import vga_pkg::*;
#(
    parameter int          X0     = 96,
    parameter int          BAR_W  = 48,
    parameter int          BASE_Y = 700,
    parameter logic [11:0] ALARM  = 12'hE00
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] hcount_in,
    input  logic [11:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic        ch_wr,
    input  logic [3:0]  ch_addr,
    input  logic [11:0] ch_data,
    output logic [11:0] hcount_out,
    output logic [11:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    localparam int X_END = X0 + NUM_CH * SLOT_W;

    logic [11:0] pending [NUM_CH];
    logic [11:0] active  [NUM_CH];
    logic        prev_vblnk;
    logic        vblank_edge;
    logic        wr_ok;

    assign vblank_edge = vblnk_in & ~prev_vblnk;
    assign wr_ok       = ch_wr && (ch_addr < 4'(NUM_CH));

    // Banks: writes land in pending; active snapshots it at vblank start.
    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                pending[i] <= '0;
                active[i]  <= '0;
            end
            prev_vblnk <= 1'b0;
        end else begin
            prev_vblnk <= vblnk_in;
            if (vblank_edge) begin
                for (int i = 0; i < NUM_CH; i++) active[i] <= pending[i];
            end
            if (wr_ok) pending[ch_addr] <= ch_data;
        end
    end

    logic [9:0]  hoff;
    logic        in_area;
    logic        s1_area;
    logic [3:0]  s1_slot;
    logic [5:0]  s1_off;
    logic [11:0] s1_vcount;
    logic        s1_blank;

    assign hoff    = 10'(hcount_in - 12'(X0));
    assign in_area = (hcount_in >= 12'(X0)) && (hcount_in < 12'(X_END));

    // Stage 1: locate the pixel within the slot grid.
    always_ff @(posedge pclk) begin
        if (rst) begin
            s1_area   <= 1'b0;
            s1_slot   <= '0;
            s1_off    <= '0;
            s1_vcount <= '0;
            s1_blank  <= 1'b0;
        end else begin
            s1_area   <= in_area;
            s1_slot   <= in_area ? hoff[9:6] : 4'd0;
            s1_off    <= hoff[5:0];
            s1_vcount <= vcount_in;
            s1_blank  <= hblnk_in | vblnk_in;
        end
    end

    logic [11:0] value;
    logic [8:0]  height;
    logic [11:0] rise;
    logic        lit;
    logic        base;
    logic        grid;
    logic [11:0] pix;

    assign value  = active[s1_slot];
    assign height = bar_height(value);
    assign rise   = 12'(BASE_Y) - s1_vcount;
    assign lit    = s1_area && (s1_off < 6'(BAR_W))
                    && (s1_vcount <= 12'(BASE_Y))
                    && (rise < {3'b000, height});
    assign base   = s1_area && (s1_vcount == 12'(BASE_Y + 1));

`ifdef DRAW_BARS_GRID_EN
    assign grid = s1_area && (s1_vcount[5:0] == 6'd0)
                  && (s1_vcount < 12'(BASE_Y));
`else
    assign grid = 1'b0;
`endif

    // Colour select, highest priority first.
    always_comb begin
        pix = RGB_BLACK;
        if (s1_blank)          pix = RGB_BLACK;
        else if (lit)          pix = (value >= ALARM) ? RGB_RED : RGB_GREEN;
        else if (base)         pix = RGB_WHITE;
        else if (grid)         pix = RGB_GRID;
    end

    // Stage 2: register the pixel colour.
    always_ff @(posedge pclk) begin
        if (rst) rgb_out <= RGB_BLACK;
        else     rgb_out <= pix;
    end

    logic [27:0] tbus_in;
    logic [27:0] tbus_out;

    assign tbus_in = {hcount_in, vcount_in, hsync_in, vsync_in,
                      hblnk_in, vblnk_in};

    signal_delay #(.WIDTH(28), .DEPTH(2)) u_delay (
        .pclk (pclk),
        .rst  (rst),
        .din  (tbus_in),
        .dout (tbus_out)
    );

    assign {hcount_out, vcount_out, hsync_out, vsync_out,
            hblnk_out, vblnk_out} = tbus_out;

endmodule

// File: tb/tb_draw_bars.sv
// Scoreboard bench for draw_bars: directed cases plus random pixels
// checked against a per-pixel reference model of the bar display.
module tb_draw_bars;

    logic        pclk = 1'b0;
    logic        rst  = 1'b1;
    logic [11:0] hcount_in = '0;
    logic [11:0] vcount_in = '0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic        hblnk_in = 1'b0;
    logic        vblnk_in = 1'b0;
    logic        ch_wr = 1'b0;
    logic [3:0]  ch_addr = '0;
    logic [11:0] ch_data = '0;
    logic [11:0] hcount_out, vcount_out, rgb_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;

    draw_bars dut (
        .pclk       (pclk),
        .rst        (rst),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .hblnk_in   (hblnk_in),
        .vblnk_in   (vblnk_in),
        .ch_wr      (ch_wr),
        .ch_addr    (ch_addr),
        .ch_data    (ch_data),
        .hcount_out (hcount_out),
        .vcount_out (vcount_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .hblnk_out  (hblnk_out),
        .vblnk_out  (vblnk_out),
        .rgb_out    (rgb_out)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    typedef struct {
        int          due;
        logic [11:0] rgb;
        logic [27:0] tbus;
        int          x;
        int          y;
        string       tag;
    } exp_t;

    exp_t q[$];

    // Reference model state: what the screen should show.
    int m_pend[13];
    int m_act[13];
    bit m_prev;

    function automatic void model_clear();
        for (int i = 0; i < 13; i++) begin
            m_pend[i] = 0;
            m_act[i]  = 0;
        end
        m_prev = 0;
    endfunction

    function automatic logic [11:0] ref_pix(int x, int y, bit blank);
        int slot, off, hgt;
        if (blank) return 12'h000;
        if (x >= 96 && x < 96 + 13 * 64) begin
            slot = (x - 96) / 64;
            off  = (x - 96) % 64;
            hgt  = m_act[slot] / 8;
            if (off < 48 && y <= 700 && (700 - y) < hgt)
                return (m_act[slot] >= 3584) ? 12'hF00 : 12'h0F0;
            if (y == 701) return 12'hFFF;
`ifdef DRAW_BARS_GRID_EN
            if (y % 64 == 0 && y < 700) return 12'h444;
`endif
        end
        return 12'h000;
    endfunction

    // Drive one pixel sample and queue the response it must produce.
    task automatic step(input int h, input int v, input bit hs,
                        input bit vs, input bit hb, input bit vb,
                        input bit wr = 0, input int addr = 0,
                        input int data = 0, input int req = -1,
                        input string tag = "pix");
        exp_t e;
        @(negedge pclk);
        hcount_in = 12'(h);
        vcount_in = 12'(v);
        hsync_in  = hs;
        vsync_in  = vs;
        hblnk_in  = hb;
        vblnk_in  = vb;
        ch_wr     = wr;
        ch_addr   = 4'(addr);
        ch_data   = 12'(data);
        if (vb && !m_prev) begin
            for (int i = 0; i < 13; i++) m_act[i] = m_pend[i];
        end
        m_prev = vb;
        if (wr && addr < 13) m_pend[addr] = data;
        e.due  = cyc + 2;
        e.rgb  = (req >= 0) ? 12'(req) : ref_pix(h, v, hb | vb);
        e.tbus = {12'(h), 12'(v), hs, vs, hb, vb};
        e.x    = h;
        e.y    = v;
        e.tag  = tag;
        q.push_back(e);
    endtask

    task automatic vblank();
        step(0, 770, 0, 1, 1, 1);
        step(0, 771, 0, 1, 1, 1);
        step(0, 772, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 0);
    endtask

    task automatic do_reset();
        @(negedge pclk);
        rst       = 1'b1;
        hcount_in = 12'd555;
        vcount_in = 12'd321;
        hsync_in  = 1'b1;
        vsync_in  = 1'b1;
        hblnk_in  = 1'b1;
        vblnk_in  = 1'b1;
        ch_wr     = 1'b0;
        q.delete();
        model_clear();
        @(posedge pclk);
        #1;
        checks++;
        if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out,
             vblnk_out, rgb_out} == 40'd0) passes++;
        else $display("FAIL reset_outputs: got h=%0d v=%0d sync=%b%b blnk=%b%b rgb=%h, want all 0",
                      hcount_out, vcount_out, hsync_out, vsync_out,
                      hblnk_out, vblnk_out, rgb_out);
        @(negedge pclk);
        rst       = 1'b0;
        hcount_in = '0;
        vcount_in = '0;
        hsync_in  = 1'b0;
        vsync_in  = 1'b0;
        hblnk_in  = 1'b0;
        vblnk_in  = 1'b0;
    endtask

    // Monitor: pop expectations as their responses reach the outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge pclk);
            #1;
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                checks++;
                if (e.due == cyc && rgb_out == e.rgb) passes++;
                else $display("FAIL %s rgb x=%0d y=%0d: got %h want %h",
                              e.tag, e.x, e.y, rgb_out, e.rgb);
                checks++;
                if (e.due == cyc && {hcount_out, vcount_out, hsync_out,
                    vsync_out, hblnk_out, vblnk_out} == e.tbus) passes++;
                else $display("FAIL %s timing x=%0d y=%0d: got %h want %h",
                              e.tag, e.x, e.y,
                              {hcount_out, vcount_out, hsync_out, vsync_out,
                               hblnk_out, vblnk_out}, e.tbus);
            end
        end
    end

    initial begin
        int h, v, a;
        bit vb;
        model_clear();
        repeat (3) @(negedge pclk);
        do_reset();

        // Partial line, reset mid-line, then a full line with hsync.
        for (int x = 0; x < 400; x++)
            step(x, 10, x >= 1048 && x < 1184, 0, x >= 1024, 0);
        do_reset();
        for (int x = 0; x < 1344; x++)
            step(x, 11, x >= 1048 && x < 1184, 0, x >= 1024, 0, 0, 0, 0,
                 -1, "line");

        // Full-scale channel 0 shows red.
        step(50, 20, 0, 0, 0, 0, 1, 0, 4095);
        vblank();
        step(96, 190, 0, 0, 0, 0, 0, 0, 0, 12'hF00, "ch0_top");
        step(96, 189, 0, 0, 0, 0, 0, 0, 0, 12'h000, "ch0_above");
        step(144, 190, 0, 0, 0, 0, 0, 0, 0, 12'h000, "ch0_edge");

        // Channel 5 green bar, baseline and edges.
        step(50, 20, 0, 0, 0, 0, 1, 5, 800);
        vblank();
        step(416, 650, 0, 0, 0, 0, 0, 0, 0, 12'h0F0, "ch5_mid");
        step(463, 601, 0, 0, 0, 0, 0, 0, 0, 12'h0F0, "ch5_top");
        step(416, 700, 0, 0, 0, 0, 0, 0, 0, 12'h0F0, "ch5_base");
        step(416, 600, 0, 0, 0, 0, 0, 0, 0, 12'h000, "ch5_above");
        step(416, 701, 0, 0, 0, 0, 0, 0, 0, 12'hFFF, "baseline");
        step(464, 650, 0, 0, 0, 0, 0, 0, 0, 12'h000, "ch5_gap");
        for (int y = 598; y < 703; y++) begin
            step(416, y, 0, 0, 0, 0, 0, 0, 0, -1, "ch5_col");
            step(463, y, 0, 0, 0, 0, 0, 0, 0, -1, "ch5_col");
            step(464, y, 0, 0, 0, 0, 0, 0, 0, -1, "ch5_col");
        end

        // Deferred update and a write coincident with the vblank edge.
        step(300, 400, 0, 0, 0, 0, 1, 3, 2000);
        step(288, 690, 0, 0, 0, 0, 0, 0, 0, 12'h000, "ch3_held");
        step(0, 770, 0, 1, 1, 1, 1, 3, 100);
        step(0, 771, 0, 1, 1, 1);
        step(0, 0, 0, 0, 1, 0);
        step(288, 690, 0, 0, 0, 0, 0, 0, 0, 12'h0F0, "ch3_new");
        step(288, 451, 0, 0, 0, 0, 0, 0, 0, 12'h0F0, "ch3_top");
        step(288, 450, 0, 0, 0, 0, 0, 0, 0, 12'h000, "ch3_above");
        vblank();
        step(288, 690, 0, 0, 0, 0, 0, 0, 0, 12'h0F0, "ch3_next");
        step(288, 688, 0, 0, 0, 0, 0, 0, 0, 12'h000, "ch3_short");

        // Out-of-range addresses leave every bar unchanged.
        step(10, 20, 0, 0, 0, 0, 1, 13, 4095);
        step(11, 20, 0, 0, 0, 0, 1, 15, 4095);
        vblank();
        for (int x = 90; x < 940; x += 7)
            step(x, 650, 0, 0, 0, 0, 0, 0, 0, -1, "badaddr");
        step(416, 650, 0, 0, 0, 0, 0, 0, 0, 12'h0F0, "badaddr_ch5");
        step(96, 300, 0, 0, 0, 0, 0, 0, 0, 12'hF00, "badaddr_ch0");

        // Grid pixel with all channels cleared.
        do_reset();
        vblank();
`ifdef DRAW_BARS_GRID_EN
        step(100, 640, 0, 0, 0, 0, 0, 0, 0, 12'h444, "grid");
`else
        step(100, 640, 0, 0, 0, 0, 0, 0, 0, 12'h000, "grid");
`endif

        // Random pixels, writes and vblank pulses against the model.
        vb = 0;
        for (int n = 0; n < 5000; n++) begin
            if ($urandom_range(0, 99) == 0) vb = ~vb;
            h = $urandom_range(0, 1100);
            v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 800)
                                            : $urandom_range(560, 720);
            a = $urandom_range(0, 15);
            step(h, v, $urandom_range(0, 1), $urandom_range(0, 1),
                 h >= 1024, vb, $urandom_range(0, 15) == 0, a,
                 ($urandom_range(0, 3) == 0) ? $urandom_range(3500, 4095)
                                             : $urandom_range(0, 4095),
                 -1, "rand");
        end

        repeat (4) @(negedge pclk);
        checks++;
        if (q.size() == 0) passes++;
        else $display("FAIL drain: got %0d outstanding want 0", q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
